// File: rtl/ahb_slv_arb_mux_if.sv
// Per-slave-port bundle between the master-side request logic and the arbitrating mux.
// The "slave" modport is the mux view; the "master" modport is the requesting side.
interface ahb_slv_arb_mux_if #(
    parameter int CHANNEL_NUM = 4,
    parameter int ADDR_W      = 46,
    parameter int DATA_W      = 32
);
    logic [CHANNEL_NUM-1:0]             req;
    logic [CHANNEL_NUM-1:0]             lock;
    logic [CHANNEL_NUM-1:0][ADDR_W-1:0] addr_in;
    logic [CHANNEL_NUM-1:0][DATA_W-1:0] wdata_in;
    logic                               hready;
    logic [CHANNEL_NUM-1:0]             grant;
    logic [CHANNEL_NUM-1:0]             data_sel;
    logic [ADDR_W-1:0]                  addr_out;
    logic                               addr_valid;
    logic [DATA_W-1:0]                  wdata_out;

    modport slave (
        input  req, lock, addr_in, wdata_in, hready,
        output grant, data_sel, addr_out, addr_valid, wdata_out
    );

    modport master (
        output req, lock, addr_in, wdata_in, hready,
        input  grant, data_sel, addr_out, addr_valid, wdata_out
    );
endinterface

// File: rtl/ahb_slv_arb_mux.sv
// Registered N-to-1 AHB slave-side arbiter/mux: picks an address-phase owner each
// hready edge (fixed or round-robin, lock-aware) and tracks the data-phase owner.
module ahb_slv_arb_mux #(
    parameter int CHANNEL_NUM = 4,
    parameter int ADDR_W      = 46,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    ahb_slv_arb_mux_if.slave      bus
);
    localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    logic [CHANNEL_NUM-1:0] grant_q, grant_d;
    logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   locked_hold_q, locked_hold_d;

    logic [PTR_W-1:0] cur_idx, fix_idx, rr_idx, nxt_idx;
    logic             rr_found;
    int               s;

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < CHANNEL_NUM; i++)
            if (grant_q[i]) cur_idx = PTR_W'(i);

        fix_idx = '0;
        for (int i = CHANNEL_NUM - 1; i >= 0; i--)
            if (bus.req[i]) fix_idx = PTR_W'(i);

        // Round robin: first requester at or above rr_ptr, wrapping
        rr_idx   = '0;
        rr_found = 1'b0;
        s        = 0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            s = int'(rr_ptr_q) + k;
            if (s >= CHANNEL_NUM) s = s - CHANNEL_NUM;
            if (!rr_found && bus.req[s]) begin
                rr_idx   = PTR_W'(s);
                rr_found = 1'b1;
            end
        end

        if (locked_hold_q && bus.req[cur_idx])
            nxt_idx = cur_idx;
        else if (|bus.req)
            nxt_idx = (ARB_MODE == 1) ? rr_idx : fix_idx;
        else
            nxt_idx = cur_idx;

        grant_d       = grant_q;
        data_sel_d    = data_sel_q;
        rr_ptr_d      = rr_ptr_q;
        locked_hold_d = locked_hold_q;

        if (bus.hready) begin
            grant_d       = '0;
            grant_d[nxt_idx] = 1'b1;
            data_sel_d    = grant_q & bus.req;
            locked_hold_d = bus.lock[nxt_idx] & bus.req[nxt_idx];
            // Parking (no granted request) leaves the pointer alone
            if (bus.req[nxt_idx])
                rr_ptr_d = (int'(nxt_idx) == CHANNEL_NUM - 1) ? '0 : nxt_idx + 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            grant_q       <= CHANNEL_NUM'(1);
            data_sel_q    <= '0;
            rr_ptr_q      <= '0;
            locked_hold_q <= 1'b0;
        end else begin
            grant_q       <= grant_d;
            data_sel_q    <= data_sel_d;
            rr_ptr_q      <= rr_ptr_d;
            locked_hold_q <= locked_hold_d;
        end
    end

    // One-hot AND-OR muxes; an all-zero data_sel yields zero write data
    always_comb begin
        bus.addr_out  = '0;
        bus.wdata_out = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            bus.addr_out  = bus.addr_out  | (bus.addr_in[i]  & {ADDR_W{grant_q[i]}});
            bus.wdata_out = bus.wdata_out | (bus.wdata_in[i] & {DATA_W{data_sel_q[i]}});
        end
    end

    assign bus.grant      = grant_q;
    assign bus.data_sel   = data_sel_q;
    assign bus.addr_valid = |(bus.req & grant_q);

endmodule

// File: tb/tb_ahb_slv_arb_mux.sv
// Directed bench for ahb_slv_arb_mux: one fixed-priority and one round-robin instance,
// expected owner/data-phase values queued per step and checked after each edge.
module tb_ahb_slv_arb_mux;
    localparam int N  = 4;
    localparam int AW = 46;
    localparam int DW = 32;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_slv_arb_mux_if #(.CHANNEL_NUM(N), .ADDR_W(AW), .DATA_W(DW)) ifc0 ();
    ahb_slv_arb_mux_if #(.CHANNEL_NUM(N), .ADDR_W(AW), .DATA_W(DW)) ifc1 ();

    ahb_slv_arb_mux #(.CHANNEL_NUM(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) u_fix (
        .hclk(hclk), .hreset(hreset), .bus(ifc0.slave));
    ahb_slv_arb_mux #(.CHANNEL_NUM(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) u_rr (
        .hclk(hclk), .hreset(hreset), .bus(ifc1.slave));

    typedef struct {
        int           m;
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic [N-1:0] rq;
        string        tag;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] addr_tab  [N];
    logic [DW-1:0] wdata_tab [N];

    function automatic logic [AW-1:0] sel_addr(input logic [N-1:0] oh);
        logic [AW-1:0] r = '0;
        for (int i = 0; i < N; i++) if (oh[i]) r = addr_tab[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] sel_wdata(input logic [N-1:0] oh);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < N; i++) if (oh[i]) r = wdata_tab[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check after the edge.
    task automatic step(input int m, input logic rst, input logic hr,
                        input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic [N-1:0] eg, input logic [N-1:0] ed, input string tag);
        exp_t e;
        logic [N-1:0]  g, d;
        logic          av;
        logic [AW-1:0] ao;
        logic [DW-1:0] wo;
        hreset = rst;
        if (m == 0) begin ifc0.req = rq; ifc0.lock = lk; ifc0.hready = hr; end
        else        begin ifc1.req = rq; ifc1.lock = lk; ifc1.hready = hr; end
        sb.push_back('{m: m, g: eg, d: ed, rq: rq, tag: tag});
        @(posedge hclk);
        #1;
        e = sb.pop_front();
        if (e.m == 0) begin
            g = ifc0.grant; d = ifc0.data_sel; av = ifc0.addr_valid;
            ao = ifc0.addr_out; wo = ifc0.wdata_out;
        end else begin
            g = ifc1.grant; d = ifc1.data_sel; av = ifc1.addr_valid;
            ao = ifc1.addr_out; wo = ifc1.wdata_out;
        end
        chk({e.tag, ".grant"},      64'(g),  64'(e.g));
        chk({e.tag, ".data_sel"},   64'(d),  64'(e.d));
        chk({e.tag, ".addr_valid"}, 64'(av), 64'(|(e.rq & e.g)));
        chk({e.tag, ".addr_out"},   64'(ao), 64'(sel_addr(e.g)));
        chk({e.tag, ".wdata_out"},  64'(wo), 64'(sel_wdata(e.d)));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            addr_tab[i]  = 46'h2A5C_0000_0000 | AW'(i * 17 + 3);
            wdata_tab[i] = 32'hD000_0000 + DW'(i) * 32'h0101_0101 + 32'h11;
            ifc0.addr_in[i]  = addr_tab[i];
            ifc0.wdata_in[i] = wdata_tab[i];
            ifc1.addr_in[i]  = addr_tab[i];
            ifc1.wdata_in[i] = wdata_tab[i];
        end
        hreset = 1'b1;
        ifc0.req = '0; ifc0.lock = '0; ifc0.hready = 1'b1;
        ifc1.req = '0; ifc1.lock = '0; ifc1.hready = 1'b1;
        #2;

        // Fixed priority
        step(0, 1, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, "reset");
        step(0, 0, 1, 4'b1010, 4'b0000, 4'b0010, 4'b0000, "fix_grant1");
        step(0, 0, 1, 4'b1010, 4'b0000, 4'b0010, 4'b0010, "fix_data1");
        step(0, 0, 1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, "lock_take2");
        step(0, 0, 1, 4'b0101, 4'b0100, 4'b0100, 4'b0100, "lock_hold_a");
        step(0, 0, 1, 4'b0101, 4'b0100, 4'b0100, 4'b0100, "lock_hold_b");
        step(0, 0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "lock_release");
        step(0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, "wait_own1");
        step(0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, "wait_dp1");
        step(0, 0, 0, 4'b0011, 4'b0000, 4'b0010, 4'b0010, "wait_k1");
        step(0, 0, 0, 4'b0011, 4'b0000, 4'b0010, 4'b0010, "wait_k2");
        step(0, 0, 0, 4'b0011, 4'b0000, 4'b0010, 4'b0010, "wait_k3");
        step(0, 0, 1, 4'b0011, 4'b0000, 4'b0001, 4'b0010, "wait_done");
        step(0, 0, 1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, "own3");
        step(0, 0, 1, 4'b1000, 4'b0000, 4'b1000, 4'b1000, "own3_dp");
        step(0, 0, 1, 4'b0000, 4'b0000, 4'b1000, 4'b0000, "park_a");
        step(0, 0, 1, 4'b0000, 4'b0000, 4'b1000, 4'b0000, "park_b");
        step(0, 0, 1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, "pre_rst_a");
        step(0, 0, 1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, "pre_rst_b");
        step(0, 1, 0, 4'b0100, 4'b0000, 4'b0001, 4'b0000, "mid_reset");
        step(0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, "post_reset");

        // Round robin (instance parked on channel 0, rr_ptr = 0)
        step(1, 0, 1, 4'b1111, 4'b0000, 4'b0001, 4'b0001, "rr_0");
        step(1, 0, 1, 4'b1111, 4'b0000, 4'b0010, 4'b0001, "rr_1");
        step(1, 0, 1, 4'b1111, 4'b0000, 4'b0100, 4'b0010, "rr_2");
        step(1, 0, 1, 4'b1111, 4'b0000, 4'b1000, 4'b0100, "rr_3");
        step(1, 0, 1, 4'b1111, 4'b0000, 4'b0001, 4'b1000, "rr_wrap");
        step(1, 0, 1, 4'b1010, 4'b0000, 4'b0010, 4'b0000, "rr_gap_a");
        step(1, 0, 1, 4'b1010, 4'b0000, 4'b1000, 4'b0010, "rr_gap_b");
        step(1, 0, 1, 4'b1010, 4'b0000, 4'b0010, 4'b1000, "rr_gap_c");
        step(1, 1, 0, 4'b1010, 4'b0000, 4'b0001, 4'b0000, "rr_mid_reset");
        step(1, 0, 1, 4'b1110, 4'b0000, 4'b0010, 4'b0000, "rr_ptr_reset");

        if (sb.size() != 0) begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ahb_slv_arb_mux.md
# ahb_slv_arb_mux

Registered, arbitrated N-to-1 AHB slave-side multiplexer. It sits in front of each slave port of the generated AHB interconnect. It selects one requesting master per address phase, using fixed-priority or round-robin arbitration with HMASTLOCK hold, and tracks the data-phase owner across wait states. Address/control and write data are steered by separate selects, so pipelined transfers from different masters stay correctly aligned.

## Interface
Parameters:
- CHANNEL_NUM, 4, number of master channels (2..16)
- ADDR_W, 46, per-channel address-phase bundle width (HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT)
- DATA_W, 32, per-channel HWDATA width
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin

Ports (clock and reset first):
- hclk  input  1  bus clock; all state on rising edge
- hreset  input  1  synchronous, active-high reset
- req  input  CHANNEL_NUM  per-master request (HTRANS NONSEQ/SEQ from decoder for this slave)
- lock  input  CHANNEL_NUM  per-master HMASTLOCK
- addr_in  input  CHANNEL_NUM x ADDR_W  per-master address-phase bundle
- wdata_in  input  CHANNEL_NUM x DATA_W  per-master write data
- hready  input  1  slave HREADYOUT; 1 = current data phase completes this cycle
- grant  output  CHANNEL_NUM  one-hot address-phase owner (registered)
- data_sel  output  CHANNEL_NUM  one-hot data-phase owner, all-zero = no data phase (registered)
- addr_out  output  ADDR_W  addr_in of granted channel
- addr_valid  output  1  |(req & grant)
- wdata_out  output  DATA_W  wdata_in of data_sel channel; 0 when data_sel == 0

## Operation
- State: grant (one-hot), data_sel (one-hot or zero), rr_ptr (log2 CHANNEL_NUM), locked_hold flag.
- Arbitration is evaluated every cycle. grant, data_sel, rr_ptr and locked_hold update only on edges where hready = 1. While hready = 0, all state holds.
- Next owner on a hready = 1 edge:
  - If locked_hold = 1 and req of the current owner = 1: keep the current owner.
  - Else, if any req: fixed mode picks the lowest set index. Round-robin mode picks the first set index searching from rr_ptr upward, wrapping modulo CHANNEL_NUM.
  - Else (no req): park on the current owner; grant is unchanged.
- locked_hold <= lock[next owner] & req[next owner].
- rr_ptr <= (index of next owner + 1) mod CHANNEL_NUM, only when a req was granted. When parking, rr_ptr is unchanged.
- data_sel <= grant & req on a hready = 1 edge. This means the registered address-phase owner becomes the data-phase owner only if its transfer was valid.
- Combinational outputs:
  - addr_out = addr_in[i] for the single i with grant[i] = 1.
  - wdata_out = wdata_in[j] for the single j with data_sel[j] = 1, else all zeros.
- grant is always exactly one-hot. data_sel is one-hot or zero; it never has more than one bit set.

## Timing
- Reset (hreset = 1 at an edge): grant = 1 (channel 0), data_sel = 0, rr_ptr = 0, locked_hold = 0. Resulting outputs: addr_out = addr_in[0], addr_valid = req[0], wdata_out = 0.
- Arbitration latency: a req first asserted in cycle n is granted at the first hready = 1 edge at or after the end of cycle n. grant is visible in cycle n+1 at the earliest.
- Data phase: data_sel follows grant by exactly one hready = 1 edge. wdata is steered in the cycle the slave samples the data phase.
- Wait states: with hready = 0 for k cycles, grant, data_sel and addr_out selection are frozen for those k cycles. A new req arriving during the wait does not preempt.
- Simultaneous events: a req and a lock release on the same hready edge are resolved by the rules above using the values sampled at that edge. The current owner dropping req while locked releases the lock on that edge.
- Reset mid-transfer: state returns to reset values on the next edge regardless of hready. The outstanding data phase is abandoned (data_sel = 0).

## Test plan
- Reset, then ARB_MODE=0, req=4'b1010, hready=1 → next cycle grant=4'b0010, addr_valid=1. One edge later data_sel=4'b0010 and wdata_out=wdata_in[1].
- ARB_MODE=1, req=4'b1111 held, hready=1 → grant sequence 0001→0010→0100→1000→0001 on successive edges. data_sel lags grant by one cycle.
- Lock hold: ARB_MODE=0, channel 2 granted with lock[2]=1 and req[2]=1, then req[0] asserted → grant stays 4'b0100 until lock[2] and req[2] drop. Grant then moves to 4'b0001 on the next hready edge.
- Wait states: granted channel 1, hready=0 for 3 cycles while req[0] rises → grant and data_sel unchanged for all 3 cycles. Grant switches only on the edge where hready=1.
- No requests: req=0 after channel 3 owned → grant parks at 4'b1000, addr_valid=0. The following edge gives data_sel=0 and wdata_out=0.
- Reset asserted while data_sel=4'b0100 and hready=0 → next cycle grant=4'b0001, data_sel=0, rr_ptr=0.
